// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit feeding the HI/LO registers.
// Radix-2 shift/add multiply and restoring shift/subtract divide, STEPS
// iterations per clock, with a final sign-fixup cycle.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset
//   start    - launch an operation (sampled only when idle)
//   flush    - abort an operation in progress; beats start when idle
//   op       - 00 MULU, 01 MUL, 10 DIVU, 11 DIV
//   opA      - multiplicand / dividend
//   opB      - multiplier / divisor
//   busy     - operation in flight (stall)
//   done     - one-cycle pulse after HI/LO are written
//   div_zero - sticky: last divide had a zero divisor
//   HIVal    - product high word or remainder
//   LOVal    - product low word or quotient
module mdu_hilo #(
  parameter int unsigned BITS  = 32,
  parameter int unsigned STEPS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [BITS-1:0] opA,
  input  logic [BITS-1:0] opB,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [BITS-1:0] HIVal,
  output logic [BITS-1:0] LOVal
);

  localparam int unsigned NITER = BITS / STEPS;
  localparam int unsigned CW    = $clog2(NITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*BITS-1:0] acc_q, acc_d;     // {hi, lo}: {partial, multiplier} or {remainder, quotient}
  logic [BITS-1:0]   opb_q, opb_d;     // |multiplicand| or |divisor|
  logic              is_div_q, is_div_d;
  logic              neg_q_q, neg_q_d; // negate product / quotient
  logic              neg_r_q, neg_r_d; // negate remainder (dividend sign)
  logic              dz_q, dz_d;       // current op is a divide by zero
  logic              done_q, done_d;
  logic              divz_q, divz_d;
  logic [BITS-1:0]   hi_q, hi_d;
  logic [BITS-1:0]   lo_q, lo_d;

  // Operand magnitudes and signs; signs only matter for the signed ops.
  logic            sign_a, sign_b;
  logic [BITS-1:0] mag_a, mag_b;

  always_comb begin
    sign_a = op[0] & opA[BITS-1];
    sign_b = op[0] & opB[BITS-1];
    mag_a  = sign_a ? -opA : opA;
    mag_b  = sign_b ? -opB : opB;
  end

  // STEPS radix-2 iterations applied to the accumulator.
  logic [2*BITS-1:0] step;
  logic [2*BITS:0]   sh;
  logic [BITS:0]     trial;
  logic [BITS:0]     sum;

  always_comb begin
    step  = acc_q;
    sh    = '0;
    trial = '0;
    sum   = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      if (is_div_q) begin
        // Restoring division: shift {rem, quo} left, try subtracting divisor.
        sh    = {step, 1'b0};
        trial = sh[2*BITS:BITS] - {1'b0, opb_q};
        if (!trial[BITS]) begin
          step = {trial[BITS-1:0], sh[BITS-1:1], 1'b1};
        end else begin
          step = sh[2*BITS-1:0];
        end
      end else begin
        // Shift-add multiply: conditionally add into the high half, keeping
        // the carry, then shift the whole accumulator right by one.
        sum  = {1'b0, step[2*BITS-1:BITS]} + (step[0] ? {1'b0, opb_q} : {(BITS+1){1'b0}});
        step = {sum, step[BITS-1:1]};
      end
    end
  end

  // Sign fixup for the FIX cycle.
  logic [2*BITS-1:0] prod_fix;
  logic [BITS-1:0]   fix_hi, fix_lo;

  always_comb begin
    prod_fix = neg_q_q ? -acc_q : acc_q;
    if (dz_q) begin
      fix_hi = acc_q[2*BITS-1:BITS];
      fix_lo = '1;
    end else if (is_div_q) begin
      fix_hi = neg_r_q ? -acc_q[2*BITS-1:BITS] : acc_q[2*BITS-1:BITS];
      fix_lo = neg_q_q ? -acc_q[BITS-1:0] : acc_q[BITS-1:0];
    end else begin
      fix_hi = prod_fix[2*BITS-1:BITS];
      fix_lo = prod_fix[BITS-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    divz_d   = divz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          is_div_d = op[1];
          neg_q_d  = sign_a ^ sign_b;
          neg_r_d  = sign_a;
          opb_d    = mag_b;
          cnt_d    = CW'(NITER);
          divz_d   = 1'b0;
          if (op[1] && (opB == '0)) begin
            // Raw dividend parked in the high half so FIX can return it as-is.
            dz_d    = 1'b1;
            acc_d   = {opA, {BITS{1'b1}}};
            state_d = S_FIX;
          end else begin
            dz_d    = 1'b0;
            acc_d   = {{BITS{1'b0}}, mag_a};
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
          divz_d = dz_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = divz_q;
  assign HIVal    = hi_q;
  assign LOVal    = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: a STEPS=1 and a STEPS=4 instance share the
// same stimulus; results, latency and flags are checked for both.
module tb_mdu_hilo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;

  logic        busy1, done1, dz1;
  logic [31:0] hi1, lo1;
  logic        busy4, done4, dz4;
  logic [31:0] hi4, lo4;

  int checks   = 0;
  int failures = 0;

  mdu_hilo #(.BITS(32), .STEPS(1)) dut1 (
    .clk(clk), .reset(rst_n), .start(start), .flush(flush), .op(op),
    .opA(opA), .opB(opB), .busy(busy1), .done(done1), .div_zero(dz1),
    .HIVal(hi1), .LOVal(lo1)
  );

  mdu_hilo #(.BITS(32), .STEPS(4)) dut4 (
    .clk(clk), .reset(rst_n), .start(start), .flush(flush), .op(op),
    .opA(opA), .opB(opB), .busy(busy4), .done(done4), .div_zero(dz4),
    .HIVal(hi4), .LOVal(lo4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy1"}, 64'(busy1), 64'd0);
    chk({tag, " done1"}, 64'(done1), 64'd0);
    chk({tag, " dz1"},   64'(dz1),   64'd0);
    chk({tag, " hilo1"}, {hi1, lo1}, 64'd0);
    chk({tag, " busy4"}, 64'(busy4), 64'd0);
    chk({tag, " done4"}, 64'(done4), 64'd0);
    chk({tag, " dz4"},   64'(dz4),   64'd0);
    chk({tag, " hilo4"}, {hi4, lo4}, 64'd0);
  endtask

  // Launch one op on both instances, wait (bounded) for each done pulse.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int lat1, input int lat4, input logic edz);
    int k;
    int k1;
    int k4;
    logic [31:0] h1, l1, h4, l4;
    logic z1, z4, b1, b4;
    k1 = -1; k4 = -1;
    h1 = 'x; l1 = 'x; h4 = 'x; l4 = 'x;
    z1 = 'x; z4 = 'x; b1 = 'x; b4 = 'x;
    @(negedge clk);
    op = o; opA = a; opB = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    opA = 32'hDEAD_BEEF;
    opB = 32'h0BAD_F00D;
    chk({tag, " busy1@E0"}, 64'(busy1), 64'd1);
    chk({tag, " busy4@E0"}, 64'(busy4), 64'd1);
    chk({tag, " dzclr1"}, 64'(dz1), 64'd0);
    chk({tag, " dzclr4"}, 64'(dz4), 64'd0);
    k = 0;
    while ((k1 < 0 || k4 < 0) && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (done1 && k1 < 0) begin
        k1 = k; h1 = hi1; l1 = lo1; z1 = dz1; b1 = busy1;
      end
      if (done4 && k4 < 0) begin
        k4 = k; h4 = hi4; l4 = lo4; z4 = dz4; b4 = busy4;
      end
    end
    chk({tag, " lat1"}, 64'(k1), 64'(lat1));
    chk({tag, " lat4"}, 64'(k4), 64'(lat4));
    chk({tag, " hilo1"}, {h1, l1}, {ehi, elo});
    chk({tag, " hilo4"}, {h4, l4}, {ehi, elo});
    chk({tag, " dz1"}, 64'(z1), 64'(edz));
    chk({tag, " dz4"}, 64'(z4), 64'(edz));
    chk({tag, " busy1@done"}, 64'(b1), 64'd0);
    chk({tag, " busy4@done"}, 64'(b4), 64'd0);
  endtask

  initial begin
    int s1;
    int s4;
    logic [31:0] r4;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; opA = '0; opB = '0;
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 9, 1'b0);
    do_op("mul_neg",  2'b01, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 9, 1'b0);
    do_op("divu",     2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        33, 9, 1'b0);
    do_op("div_neg",  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 9, 1'b0);
    do_op("div_ovf",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 9, 1'b0);
    do_op("mulu_big", 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080, 33, 9, 1'b0);
    do_op("div_zero", 2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1,  1, 1'b1);

    // MULU 5*6: start re-pulsed at E5 (ignored), flush sampled at E11.
    @(negedge clk);
    op = 2'b00; opA = 32'd5; opB = 32'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("flush dzclr1", 64'(dz1), 64'd0);
    s1 = -1; s4 = -1; r4 = 'x;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (done1 && s1 < 0) s1 = k;
      if (done4 && s4 < 0) begin
        s4 = k; r4 = lo4;
      end
      if (k == 4) start = 1'b1;
      if (k == 5) start = 1'b0;
      if (k == 10) flush = 1'b1;
      if (k == 11) begin
        flush = 1'b0;
        chk("flush idle1", 64'(busy1), 64'd0);
      end
    end
    chk("flush nodone1", 64'(s1), -64'sd1);
    chk("flush hilo1", {hi1, lo1}, 64'h0000_1234_FFFF_FFFF);
    chk("flush dz1", 64'(dz1), 64'd0);
    chk("restart ign lat4", 64'(s4), 64'd9);
    chk("restart ign lo4", 64'(r4), 64'd30);

    do_op("mulu_rerun", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 33, 9, 1'b0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    op = 2'b00; opA = 32'hFFFF_FFFF; opB = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
    end
    #1;
    chk("pre-reset busy1", 64'(busy1), 64'd1);
    chk("pre-reset hilo4", {hi4, lo4}, 64'hFFFF_FFFE_0000_0001);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit for the bus datapath. It replaces the single-cycle MUL/DIV path into RZ/HI/LO.
- Operands are taken from the bus-side registers (RY and busLO) on a start pulse. The unit runs a parametrised number of radix-2 steps per clock.
- On completion it writes a 2*BITS result into internal HI/LO registers, which the datapath selects onto busHI/busLO.
- busy drives the control-unit stall.

Parameters:
- BITS, 32, operand width; HI and LO are each BITS wide.
- STEPS, 1, shift/add (or shift/subtract) steps per clock. Must divide BITS; legal values are 1, 2 and 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  sampled only in IDLE; launches an operation
- flush  input  1  aborts an operation in progress
- op  input  2  00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed)
- opA  input  BITS  multiplicand / dividend (RY value)
- opB  input  BITS  multiplier / divisor (busLO value)
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when HI/LO are updated
- div_zero  output  1  sticky flag: last divide had divisor 0
- HIVal  output  BITS  product high word, or remainder
- LOVal  output  BITS  product low word, or quotient

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; busy, done, div_zero = 0; HIVal, LOVal = 0; counter = 0.
  - Takes effect immediately, including mid-operation; the operation is lost.
- State machine: IDLE, RUN, FIX.
- IDLE:
  - On an edge with start=1 and flush=0, latch |opA|, |opB|, the sign flags (signed ops only) and op. Load counter = BITS/STEPS.
  - Clear div_zero. Go to RUN; busy=1 from the next cycle.
- Divide by zero: if op is a divide and opB=0 on the start edge, go to FIX instead of RUN.
  - FIX sets div_zero=1, HI=opA (unmodified), LO = all ones.
- RUN:
  - Each edge performs STEPS radix-2 steps and decrements the counter by 1.
  - At counter=1 the next edge enters FIX.
  - Multiply: unsigned shift-add on magnitudes into a 2*BITS accumulator.
  - Divide: restoring shift-subtract on magnitudes giving quotient and remainder.
- FIX (one edge):
  - Apply sign correction and write HI/LO. done=1 for the following cycle only; busy=0 in that same cycle; go to IDLE.
  - Signed multiply: negate the 2*BITS product if the operand signs differ.
  - Signed divide: quotient truncates toward zero and is negated if the signs differ; remainder takes the dividend's sign.
  - 0x80000000 / -1 (BITS=32) gives LO=0x80000000, HI=0. No trap.
- Latency:
  - Start edge E0, FIX edge E(BITS/STEPS+1).
  - 33 edges for BITS=32, STEPS=1; 9 edges for STEPS=4; 1 edge for divide-by-zero.
- Handshake:
  - start while busy is ignored; no queueing and no restart.
  - Operands are not resampled after E0, so the bus may change freely.
- flush:
  - In RUN or FIX: next edge returns to IDLE, busy=0, no done pulse, HI/LO and div_zero unchanged.
  - In IDLE: flush beats a simultaneous start; start is ignored.
- HI/LO hold their value until the next FIX. They are never partially updated.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted on that edge since the state is IDLE.

Test Plan:
- MULU, opA=opB=0xFFFFFFFF, start at E0 -> busy for 33 cycles; done pulse after E33; HI=0xFFFFFFFE, LO=0x00000001.
- MUL, opA=0xFFFFFFF9 (-7), opB=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIVU 100/7 -> LO=14, HI=2.
- DIV, opA=-7, opB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV, opA=0x1234, opB=0 -> done after E1, div_zero=1, HI=0x1234, LO=0xFFFFFFFF. Next accepted start clears div_zero.
- MULU 5*6 with start re-pulsed at E5 (ignored) and flush at E10 -> IDLE at E11, no done, HI/LO keep prior values. Re-run completes with LO=30.
- Second run with reset=0 at E12 mid-operation -> all outputs 0 immediately.
- STEPS=4 instance: MULU 0x12345678*0x9ABCDEF0 -> done after E9, {HI,LO} = 0x0B00EA4E_242D2080. Results match STEPS=1 for all cases above.
